// File: rtl/mealy_seq_ctrl.sv
// Sequencer that resets the 2-bit serial Mealy detector, shifts a pattern into it LSB first and tallies y==2'b11 steps.
// Optional MEALY_SEQ_TRACE_EN adds trace_o holding every sampled y of the last run.
module mealy_seq_ctrl #(
  parameter int  MAX_LEN = 16,
  parameter int  DIV     = 4,
  localparam int LW      = $clog2(MAX_LEN) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LW-1:0]      len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               fsm_rst_no,
  output logic               fsm_x_o,
  input  logic [1:0]         fsm_y_i,
  output logic [LW-1:0]      hits_o,
  output logic [1:0]         last_y_o
`ifdef MEALY_SEQ_TRACE_EN
  ,
  output logic [2*MAX_LEN-1:0] trace_o
`endif
);

  localparam int              DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
  localparam logic [LW-1:0]   LEN_MAX  = LW'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_e;

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic               x_q;
  logic [MAX_LEN-1:0] shift_q;
  logic [LW-1:0]      rem_q;
  logic [DW-1:0]      div_q;
  logic [LW-1:0]      hits_q;
  logic [1:0]         last_y_q;

  logic [LW-1:0]      len_eff;
  logic [MAX_LEN-1:0] shift_nxt;
  logic [LW-1:0]      hit_inc;

`ifdef MEALY_SEQ_TRACE_EN
  logic [LW-1:0]        step_q;
  logic [2*MAX_LEN-1:0] trace_q;
`endif

  assign len_eff   = (len_i > LEN_MAX) ? LEN_MAX : len_i;
  assign shift_nxt = shift_q >> 1;
  assign hit_inc   = LW'(fsm_y_i == 2'b11);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= 1'b0;
      div_q    <= '0;
      hits_q   <= '0;
      last_y_q <= '0;
`ifdef MEALY_SEQ_TRACE_EN
      step_q   <= '0;
      trace_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            hits_q   <= '0;
            last_y_q <= '0;
`ifdef MEALY_SEQ_TRACE_EN
            step_q   <= '0;
            trace_q  <= '0;
`endif
            if (len_eff != '0) begin
              shift_q <= pattern_i;
              rem_q   <= len_eff;
              busy_q  <= 1'b1;
              state_q <= CLEAR;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        CLEAR: begin
          div_q   <= '0;
          x_q     <= shift_q[0];
          state_q <= RUN;
        end
        RUN: begin
          // The detector advances on this same edge, so y still reflects the current step.
          if (div_q == DIV_LAST) begin
            last_y_q <= fsm_y_i;
            hits_q   <= hits_q + hit_inc;
`ifdef MEALY_SEQ_TRACE_EN
            trace_q[{step_q, 1'b0} +: 2] <= fsm_y_i;
            step_q   <= step_q + LW'(1);
`endif
            shift_q  <= shift_nxt;
            rem_q    <= rem_q - LW'(1);
            div_q    <= '0;
            x_q      <= shift_nxt[0];
            if (rem_q == LW'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              x_q     <= 1'b0;
              state_q <= DONE;
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Detector is held in reset together with the controller and for the single CLEAR cycle.
  assign fsm_rst_no = ~rst_i & (state_q != CLEAR);
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign fsm_x_o    = x_q;
  assign hits_o     = hits_q;
  assign last_y_o   = last_y_q;
`ifdef MEALY_SEQ_TRACE_EN
  assign trace_o    = trace_q;
`endif

endmodule

// File: tb/tb_mealy_seq_ctrl.sv
// Bench for mealy_seq_ctrl: a step-rate detector stand-in feeds y back; each run is checked cycle by cycle.
module tb_mealy_seq_ctrl;
  localparam int MAX_LEN = 16;
  localparam int DIV     = 4;
  localparam int LW      = $clog2(MAX_LEN) + 1;

  logic               clk = 1'b0;
  logic               rst_i;
  logic               start_i;
  logic [MAX_LEN-1:0] pattern_i;
  logic [LW-1:0]      len_i;
  logic               busy_o;
  logic               done_o;
  logic               fsm_rst_no;
  logic               fsm_x_o;
  logic [1:0]         fsm_y_i;
  logic [LW-1:0]      hits_o;
  logic [1:0]         last_y_o;
`ifdef MEALY_SEQ_TRACE_EN
  logic [2*MAX_LEN-1:0] trace_o;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mealy_seq_ctrl #(.MAX_LEN(MAX_LEN), .DIV(DIV)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .pattern_i  (pattern_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .fsm_rst_no (fsm_rst_no),
    .fsm_x_o    (fsm_x_o),
    .fsm_y_i    (fsm_y_i),
    .hits_o     (hits_o),
    .last_y_o   (last_y_o)
`ifdef MEALY_SEQ_TRACE_EN
    ,
    .trace_o    (trace_o)
`endif
  );

  // Detector stand-in: advances once per DIV cycles after its reset; y[0]=previous x, y[1]=three 1s in a row.
  logic [1:0] det_h;
  int         det_cnt;
  always @(posedge clk) begin
    if (!fsm_rst_no) begin
      det_h   <= 2'b00;
      det_cnt <= 0;
    end else if (det_cnt == DIV - 1) begin
      det_cnt <= 0;
      det_h   <= {det_h[0], fsm_x_o};
    end else begin
      det_cnt <= det_cnt + 1;
    end
  end
  assign fsm_y_i = {det_h[1] & det_h[0] & fsm_x_o, det_h[0]};

  // Expected y at step k, taken straight from the pattern bits.
  function automatic logic [1:0] model_y(input logic [MAX_LEN-1:0] p, input int k);
    logic b0, b1, b2;
    b0 = p[k];
    b1 = (k >= 1) ? p[k-1] : 1'b0;
    b2 = (k >= 2) ? p[k-2] : 1'b0;
    return {b0 & b1 & b2, b1};
  endfunction

  task automatic run_check(input string name, input logic [MAX_LEN-1:0] pat, input int len, input bit poke);
    int                   L;
    int                   last_c;
    logic [LW-1:0]        eh;
    logic [1:0]           el;
    logic [1:0]           yk;
    logic [2*MAX_LEN-1:0] et;
    logic [3:0]           act;
    logic [3:0]           exp_v;
    L  = (len > MAX_LEN) ? MAX_LEN : len;
    eh = '0;
    el = 2'b00;
    et = '0;
    for (int k = 0; k < L; k++) begin
      yk = model_y(pat, k);
      et[2*k +: 2] = yk;
      el = yk;
      if (yk == 2'b11) eh = eh + 1'b1;
    end
    last_c = (L == 0) ? 1 : 2 + L * DIV;
    @(negedge clk);
    vectors++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle: busy=%b done=%b, want 0 0", name, busy_o, done_o);
    end
    start_i   = 1'b1;
    pattern_i = pat;
    len_i     = LW'(len);
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c == last_c)  exp_v = 4'b0110;
      else if (c == 1)  exp_v = 4'b1000;
      else              exp_v = {3'b101, pat[(c-2)/DIV]};
      act = {busy_o, done_o, fsm_rst_no, fsm_x_o};
      vectors++;
      if (act !== exp_v) begin
        miscompares++;
        $display("FAIL %s cycle %0d {busy,done,rst_n,x}: got %b want %b", name, c, act, exp_v);
      end
`ifdef MEALY_SEQ_TRACE_EN
      if (c == 1) begin
        vectors++;
        if (trace_o !== '0) begin
          miscompares++;
          $display("FAIL %s trace clear: got %h want 0", name, trace_o);
        end
      end
`endif
      if (poke && c == 5) begin
        start_i   = 1'b1;
        pattern_i = ~pat;
        len_i     = LW'(1);
      end
    end
    vectors++;
    if (hits_o !== eh || last_y_o !== el) begin
      miscompares++;
      $display("FAIL %s result: hits=%0d last_y=%b, want hits=%0d last_y=%b", name, hits_o, last_y_o, eh, el);
    end
`ifdef MEALY_SEQ_TRACE_EN
    vectors++;
    if (trace_o !== et) begin
      miscompares++;
      $display("FAIL %s trace: got %h want %h", name, trace_o, et);
    end
`endif
  endtask

  task automatic test_reset;
    rst_i     = 1'b1;
    start_i   = 1'b0;
    pattern_i = '0;
    len_i     = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (fsm_rst_no !== 1'b0) begin
      miscompares++;
      $display("FAIL reset rst_n: got %b want 0", fsm_rst_no);
    end
    rst_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy_o, done_o, fsm_rst_no, fsm_x_o} !== 4'b0010 || hits_o !== '0 || last_y_o !== 2'b00) begin
      miscompares++;
      $display("FAIL reset state: busy=%b done=%b rst_n=%b x=%b hits=%0d last=%b, want 0 0 1 0 0 00",
               busy_o, done_o, fsm_rst_no, fsm_x_o, hits_o, last_y_o);
    end
  endtask

  task automatic test_basic;
    run_check("basic", 16'h0007, 4, 1'b0);
  endtask

  task automatic test_five_ones;
    run_check("five_ones", 16'h001F, 5, 1'b0);
  endtask

  task automatic test_zero_len;
    run_check("zero_len", 16'hFFFF, 0, 1'b0);
  endtask

  task automatic test_ignore_start;
    run_check("ignore_start", 16'h0007, 4, 1'b1);
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    start_i   = 1'b1;
    pattern_i = 16'h0007;
    len_i     = LW'(4);
    @(negedge clk);
    start_i = 1'b0;
    repeat (2 * DIV + 1) @(negedge clk);
    vectors++;
    if (busy_o !== 1'b1 || last_y_o !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_reset pre: busy=%b last_y=%b, want 1 01", busy_o, last_y_o);
    end
    rst_i = 1'b1;
    #1;
    vectors++;
    if (fsm_rst_no !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset rst_n: got %b want 0", fsm_rst_no);
    end
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    vectors++;
    if ({busy_o, done_o, fsm_rst_no, fsm_x_o} !== 4'b0010 || hits_o !== '0 || last_y_o !== 2'b00) begin
      miscompares++;
      $display("FAIL mid_reset post: busy=%b done=%b rst_n=%b x=%b hits=%0d last=%b, want 0 0 1 0 0 00",
               busy_o, done_o, fsm_rst_no, fsm_x_o, hits_o, last_y_o);
    end
`ifdef MEALY_SEQ_TRACE_EN
    vectors++;
    if (trace_o !== '0) begin
      miscompares++;
      $display("FAIL mid_reset trace: got %h want 0", trace_o);
    end
`endif
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clk);
      vectors++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_reset idle %0d: done=%b busy=%b, want 0 0", i, done_o, busy_o);
      end
    end
    run_check("after_reset", 16'h0007, 4, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_check("b2b_a", 16'h00F3, 8, 1'b0);
    run_check("b2b_b", 16'h0000, 0, 1'b0);
    run_check("b2b_c", 16'h0E0E, 12, 1'b0);
  endtask

  task automatic test_clamp;
    run_check("clamp_16", 16'hBEEF, 16, 1'b0);
    run_check("clamp_20", 16'hF7FF, 20, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      run_check("random", MAX_LEN'($urandom), int'($urandom_range(0, MAX_LEN + 3)), i[0]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_five_ones;
    test_zero_len;
    test_ignore_start;
    test_mid_reset;
    test_back_to_back;
    test_clamp;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
